// File: rtl/spi_reg_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } spi_state_e;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Two-flop synchronisers for the SPI pins plus SCLK edge detection.
module spi_in_sync (
    input  logic clk,
    input  logic reset,
    input  logic copi_pin,
    input  logic ncs_pin,
    input  logic sclk_pin,
    output logic copi_sync,
    output logic ncs_sync,
    output logic sclk_rise_c,
    output logic sclk_fall_c
);

    logic copi_meta;
    logic ncs_meta;
    logic sclk_meta;
    logic sclk_sync;
    logic sclk_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            copi_meta <= 1'b0;
            copi_sync <= 1'b0;
            ncs_meta  <= 1'b1;
            ncs_sync  <= 1'b1;
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_prev <= 1'b0;
        end else begin
            copi_meta <= copi_pin;
            copi_sync <= copi_meta;
            ncs_meta  <= ncs_pin;
            ncs_sync  <= ncs_meta;
            sclk_meta <= sclk_pin;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
        end
    end

    assign sclk_rise_c = sclk_sync & ~sclk_prev;
    assign sclk_fall_c = ~sclk_sync & sclk_prev;

endmodule

// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 register file with readback and write strobe.
// Optional SPI_FRAME_ERR_EN adds a sticky short/long-frame error flag and counter.
module spi_reg_peripheral
    import spi_reg_pkg::*;
#(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 5,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       COPI,
    input  logic                       nCS,
    input  logic                       SCLK,
    output logic                       CIPO,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic                       frame_err,
    output logic [7:0]                 frame_err_cnt
`endif
);

    localparam int unsigned FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int unsigned CMD_W   = 1 + ADDR_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
    localparam int unsigned SH_W    = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;

    logic copi_sync, ncs_sync, sclk_rise_c, sclk_fall_c;

    spi_in_sync u_sync (
        .clk         (clk),
        .reset       (reset),
        .copi_pin    (COPI),
        .ncs_pin     (nCS),
        .sclk_pin    (SCLK),
        .copi_sync   (copi_sync),
        .ncs_sync    (ncs_sync),
        .sclk_rise_c (sclk_rise_c),
        .sclk_fall_c (sclk_fall_c)
    );

    spi_state_e          state, state_next;
    logic [CNT_W-1:0]    cnt;
    logic [SH_W-1:0]     shreg;
    logic                rw_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   out_sh;
    logic [1:0]          settle;
    logic                armed;
    logic                shift_c, load_c, commit_c;
    logic                mapped_c, reserved_c;
    logic [CMD_W-1:0]    cmd_word_c;
    logic [DATA_W-1:0]   data_word_c;
    logic [DATA_W-1:0]   rd_c;

    assign cmd_word_c  = CMD_W'({shreg, copi_sync});
    assign data_word_c = DATA_W'({shreg, copi_sync});

`ifdef SPI_FRAME_ERR_EN
    localparam logic [ADDR_W-1:0] RSVD_ADDR = '1;
    assign reserved_c = (addr_q == RSVD_ADDR);
`else
    assign reserved_c = 1'b0;
`endif
    assign mapped_c = (32'(addr_q) < NUM_REGS) && !reserved_c;

    // Readback source for the address just received; unmapped reads return zero.
    always_comb begin
        rd_c = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (ADDR_W'(i) == cmd_word_c[ADDR_W-1:0]) rd_c = regs_out[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        shift_c    = 1'b0;
        load_c     = 1'b0;
        commit_c   = 1'b0;
        if (ncs_sync) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (armed) state_next = CMD;
                CMD: begin
                    if (sclk_rise_c) begin
                        shift_c = 1'b1;
                        if (cnt == CNT_W'(CMD_W - 1)) begin
                            state_next = DATA;
                            load_c     = 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (sclk_rise_c) begin
                        shift_c = 1'b1;
                        if (cnt == CNT_W'(FRAME_W - 1)) begin
                            state_next = DONE;
                            commit_c   = (rw_q == RW_WRITE);
                        end
                    end
                end
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            shreg     <= '0;
            rw_q      <= RW_READ;
            addr_q    <= '0;
            out_sh    <= '0;
            settle    <= '0;
            armed     <= 1'b0;
            CIPO      <= 1'b0;
            cipo_oe   <= 1'b0;
            regs_out  <= RESET_VAL;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
        end else begin
            cipo_oe   <= ~ncs_sync;
            wr_strobe <= 1'b0;
            // Arm only once the synchronisers reflect the pin and nCS has been seen high,
            // so a frame in progress across reset is ignored.
            if (settle != 2'd2)  settle <= settle + 2'd1;
            else if (ncs_sync)   armed  <= 1'b1;

            if (state == IDLE)                                cnt <= '0;
            else if (shift_c && cnt != CNT_W'(FRAME_W))       cnt <= cnt + CNT_W'(1);
            if (shift_c) shreg <= SH_W'({shreg, copi_sync});

            if (load_c) begin
                rw_q   <= cmd_word_c[ADDR_W];
                addr_q <= cmd_word_c[ADDR_W-1:0];
            end

            if (load_c) begin
                out_sh <= (cmd_word_c[ADDR_W] == RW_READ) ? rd_c : '0;
                CIPO   <= 1'b0;
            end else if (state_next != DATA) begin
                CIPO   <= 1'b0;
            end else if (sclk_fall_c) begin
                CIPO   <= out_sh[DATA_W-1];
                out_sh <= DATA_W'({out_sh, 1'b0});
            end

            if (commit_c && mapped_c) begin
                wr_strobe <= 1'b1;
                wr_addr   <= addr_q;
                for (int i = 0; i < int'(NUM_REGS); i++) begin
                    if (ADDR_W'(i) == addr_q) regs_out[i*DATA_W +: DATA_W] <= data_word_c;
                end
            end
        end
    end

`ifdef SPI_FRAME_ERR_EN
    logic ncs_prev;
    logic overrun;

    // A frame ending short, mid-way, or with extra clocks past DONE counts as an error.
    always_ff @(posedge clk) begin
        if (reset) begin
            ncs_prev      <= 1'b1;
            overrun       <= 1'b0;
            frame_err     <= 1'b0;
            frame_err_cnt <= '0;
        end else begin
            ncs_prev <= ncs_sync;
            if (state == IDLE)                                  overrun <= 1'b0;
            else if (state == DONE && sclk_rise_c && !ncs_sync) overrun <= 1'b1;

            if (commit_c && reserved_c) begin
                frame_err     <= 1'b0;
                frame_err_cnt <= '0;
            end else if (ncs_sync && !ncs_prev &&
                         ((cnt != '0 && cnt != CNT_W'(FRAME_W)) || overrun)) begin
                frame_err <= 1'b1;
                if (frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Directed bench for spi_reg_peripheral acting as an SPI mode-0 master.
module tb_spi_reg_peripheral;

    logic        clk = 1'b0;
    logic        reset;
    logic        COPI;
    logic        nCS;
    logic        SCLK;
    logic        CIPO;
    logic        cipo_oe;
    logic [39:0] regs_out;
    logic        wr_strobe;
    logic [6:0]  wr_addr;
`ifdef SPI_FRAME_ERR_EN
    logic        frame_err;
    logic [7:0]  frame_err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int strobe_total = 0;

    spi_reg_peripheral dut (
        .clk       (clk),
        .reset     (reset),
        .COPI      (COPI),
        .nCS       (nCS),
        .SCLK      (SCLK),
        .CIPO      (CIPO),
        .cipo_oe   (cipo_oe),
        .regs_out  (regs_out),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr)
`ifdef SPI_FRAME_ERR_EN
        ,
        .frame_err     (frame_err),
        .frame_err_cnt (frame_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_strobe) strobe_total <= strobe_total + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Shift out the low nbits of frame MSB first; capture CIPO on data bits 8..15.
    task automatic spi_xfer(input logic [31:0] frame, input int nbits, input bit release_cs,
                            output logic [7:0] rd, output int oe_bad);
        rd     = '0;
        oe_bad = 0;
        nCS    = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            COPI = frame[nbits-1-i];
            repeat (6) @(negedge clk);
            if (!cipo_oe) oe_bad++;
            if (i >= 8 && i < 16) rd = {rd[6:0], CIPO};
            SCLK = 1'b1;
            repeat (6) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (6) @(negedge clk);
        if (release_cs) begin
            nCS = 1'b1;
            repeat (10) @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] rd;
        int         oe_bad;
        int         s0;

        reset = 1'b1;
        nCS   = 1'b1;
        SCLK  = 1'b0;
        COPI  = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_regs",    64'(regs_out),  64'h0);
        check("reset_strobe",  64'(wr_strobe), 64'h0);
        check("reset_wr_addr", 64'(wr_addr),   64'h0);
        check("reset_cipo",    64'(CIPO),      64'h0);
        check("reset_oe",      64'(cipo_oe),   64'h0);
        repeat (10) @(negedge clk);

        // Write 0xF0 to reg0
        s0 = strobe_total;
        spi_xfer(32'h80F0, 16, 1'b1, rd, oe_bad);
        check("w0_regs",    64'(regs_out),         64'h00_00_00_00_F0);
        check("w0_strobe",  64'(strobe_total - s0), 64'd1);
        check("w0_wr_addr", 64'(wr_addr),          64'h0);

        // Write 0x55 to reg4, then read it back
        s0 = strobe_total;
        spi_xfer(32'h8455, 16, 1'b1, rd, oe_bad);
        check("w4_regs",    64'(regs_out),         64'h55_00_00_00_F0);
        check("w4_strobe",  64'(strobe_total - s0), 64'd1);
        check("w4_wr_addr", 64'(wr_addr),          64'h4);
        s0 = strobe_total;
        spi_xfer(32'h0400, 16, 1'b1, rd, oe_bad);
        check("r4_data",    64'(rd),               64'h55);
        check("r4_oe",      64'(oe_bad),           64'd0);
        check("r4_strobe",  64'(strobe_total - s0), 64'd0);
        check("r4_regs",    64'(regs_out),         64'h55_00_00_00_F0);
        check("idle_cipo",  64'(CIPO),             64'h0);
        check("idle_oe",    64'(cipo_oe),          64'h0);

        // Unmapped write and read at address 0x7F
        s0 = strobe_total;
        spi_xfer(32'hFFAA, 16, 1'b1, rd, oe_bad);
        check("unm_strobe",  64'(strobe_total - s0), 64'd0);
        check("unm_regs",    64'(regs_out),         64'h55_00_00_00_F0);
        check("unm_wr_addr", 64'(wr_addr),          64'h4);
        spi_xfer(32'h7F00, 16, 1'b1, rd, oe_bad);
        check("unm_read",    64'(rd),               64'h00);

        // Abort after 10 bits of 0x81CC, then a complete frame
        s0 = strobe_total;
        spi_xfer(32'h207, 10, 1'b1, rd, oe_bad);
        check("abort_regs",   64'(regs_out),         64'h55_00_00_00_F0);
        check("abort_strobe", 64'(strobe_total - s0), 64'd0);
        s0 = strobe_total;
        spi_xfer(32'h81CC, 16, 1'b1, rd, oe_bad);
        check("w1_regs",    64'(regs_out),         64'h55_00_00_CC_F0);
        check("w1_strobe",  64'(strobe_total - s0), 64'd1);
        check("w1_wr_addr", 64'(wr_addr),          64'h1);

        // Reset after 12 bits of 0x8233; remaining 4 bits must be ignored
        s0 = strobe_total;
        spi_xfer(32'h823, 12, 1'b0, rd, oe_bad);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_mid_regs", 64'(regs_out), 64'h0);
        spi_xfer(32'h3, 4, 1'b1, rd, oe_bad);
        check("rst_tail_regs",   64'(regs_out),         64'h0);
        check("rst_tail_strobe", 64'(strobe_total - s0), 64'd0);
        check("rst_tail_addr",   64'(wr_addr),          64'h0);
        spi_xfer(32'h8233, 16, 1'b1, rd, oe_bad);
        check("w2_regs",    64'(regs_out), 64'h00_00_33_00_00);
        check("w2_wr_addr", 64'(wr_addr),  64'h2);

`ifdef SPI_FRAME_ERR_EN
        check("ferr_clear0", 64'(frame_err),     64'h0);
        spi_xfer(32'h0, 9, 1'b1, rd, oe_bad);
        check("ferr_short",  64'(frame_err_cnt), 64'd1);
        spi_xfer(32'h0, 20, 1'b1, rd, oe_bad);
        check("ferr_flag",   64'(frame_err),     64'h1);
        check("ferr_cnt",    64'(frame_err_cnt), 64'd2);
        spi_xfer(32'hFF00, 16, 1'b1, rd, oe_bad);
        check("ferr_clr",    64'(frame_err),     64'h0);
        check("ferr_clrcnt", 64'(frame_err_cnt), 64'd0);
        check("ferr_regs",   64'(regs_out),      64'h00_00_33_00_00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
